// File: rtl/spi_reg_bank.sv
// Command/address interpreter and register bank behind the SPI receive path.
// Writes auto-increment from a command address; reads serialize registers onto poci.
module spi_reg_bank #(
    parameter int          NUM_REGS  = 16,
    parameter logic [7:0]  RESET_VAL = 8'h00
) (
    input  logic                  sclk,
    input  logic                  rstn,
    input  logic                  frame_rstn,
    input  logic [7:0]            byte_in,
    input  logic                  byte_valid,
    output logic [8*NUM_REGS-1:0] reg_out,
    output logic                  poci,
    output logic                  wr_strobe,
    output logic [6:0]            wr_addr,
    output logic                  rd_active
);

    localparam logic [1:0] ST_CMD   = 2'd0;
    localparam logic [1:0] ST_WRITE = 2'd1;
    localparam logic [1:0] ST_READ  = 2'd2;

    logic [1:0] state_q, state_d;
    logic [6:0] ptr_q, ptr_d;
    logic [7:0] shreg_q, shreg_d;
    logic       wr_strobe_q, wr_strobe_d;
    logic [6:0] wr_addr_q, wr_addr_d;
    logic [7:0] regs_q [NUM_REGS];
    logic       poci_q;
    logic       wr_en;
    logic [6:0] rd_addr;
    logic [7:0] rd_data;
    logic       frame_rst_n;

    // Frame state is cleared by either reset; the register bank only by rstn.
    assign frame_rst_n = rstn & frame_rstn;

    // The command byte addresses the first read directly; later reads use ptr.
    always_comb begin
        rd_addr = (state_q == ST_CMD) ? byte_in[6:0] : ptr_q;
        rd_data = 8'h00;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_addr == 7'(i)) rd_data = regs_q[i];
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d   = state_q;
        ptr_d     = ptr_q;
        shreg_d   = shreg_q;
        wr_addr_d = wr_addr_q;
        wr_en     = 1'b0;
        case (state_q)
            ST_CMD: begin
                if (byte_valid) begin
                    ptr_d = byte_in[6:0];
                    if (byte_in[7]) begin
                        state_d = ST_READ;
                        shreg_d = rd_data;
                        ptr_d   = byte_in[6:0] + 7'd1;
                    end else begin
                        state_d = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                if (byte_valid) begin
                    wr_en     = ({1'b0, ptr_q} < 8'(NUM_REGS));
                    wr_addr_d = ptr_q;
                    ptr_d     = ptr_q + 7'd1;
                end
            end
            ST_READ: begin
                if (byte_valid) begin
                    shreg_d = rd_data;
                    ptr_d   = ptr_q + 7'd1;
                end else begin
                    shreg_d = {shreg_q[6:0], 1'b0};
                end
            end
            default: state_d = ST_CMD;
        endcase
        wr_strobe_d = wr_en;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge sclk or negedge frame_rst_n) begin
        if (!frame_rst_n) begin
            state_q     <= ST_CMD;
            ptr_q       <= 7'd0;
            shreg_q     <= 8'h00;
            wr_strobe_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            shreg_q     <= shreg_d;
            wr_strobe_q <= wr_strobe_d;
        end
    end

    // NOTE: the bank is built from flops, not RAM, so every entry is reset to a known value.
    always_ff @(posedge sclk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VAL;
            wr_addr_q <= 7'd0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_en && (ptr_q == 7'(i))) regs_q[i] <= byte_in;
            end
            wr_addr_q <= wr_addr_d;
        end
    end

    // Launching poci on the falling edge gives the host a full half cycle of setup.
    always_ff @(negedge sclk or negedge frame_rst_n) begin
        if (!frame_rst_n) poci_q <= 1'b0;
        else              poci_q <= shreg_q[7];
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
        assign reg_out[8*g +: 8] = regs_q[g];
    end

    assign poci      = poci_q;
    assign wr_strobe = wr_strobe_q;
    assign wr_addr   = wr_addr_q;
    assign rd_active = (state_q == ST_READ);

endmodule

// File: tb/tb_spi_reg_bank.sv
// Directed bench for spi_reg_bank: burst write/read, out-of-range and wrap,
// mid-frame reset and reset priority, with hand-computed expectations.
module tb_spi_reg_bank;

    localparam int         NREGS = 16;
    localparam logic [7:0] RVAL  = 8'hA5;

    logic                sclk = 1'b0;
    logic                rstn;
    logic                frame_rstn;
    logic [7:0]          byte_in;
    logic                byte_valid;
    logic [8*NREGS-1:0]  reg_out;
    logic                poci;
    logic                wr_strobe;
    logic [6:0]          wr_addr;
    logic                rd_active;

    int n_checks = 0;
    int n_errors = 0;

    spi_reg_bank #(.NUM_REGS(NREGS), .RESET_VAL(RVAL)) dut (
        .sclk       (sclk),
        .rstn       (rstn),
        .frame_rstn (frame_rstn),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .reg_out    (reg_out),
        .poci       (poci),
        .wr_strobe  (wr_strobe),
        .wr_addr    (wr_addr),
        .rd_active  (rd_active)
    );

    always #5 sclk = ~sclk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] reg_at(input int i);
        return reg_out[8*i +: 8];
    endfunction

    // Present one byte; returns 2 time units after the posedge that samples it.
    task automatic strobe(input logic [7:0] b);
        byte_in    = b;
        byte_valid = 1'b1;
        @(posedge sclk);
        #2;
        byte_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge sclk);
        #2;
    endtask

    task automatic end_frame();
        frame_rstn = 1'b0;
        #2;
        frame_rstn = 1'b1;
    endtask

    task automatic read_bits(input int n, output logic [7:0] v);
        v = 8'h00;
        repeat (n) begin
            @(negedge sclk);
            #1;
            v = {v[6:0], poci};
        end
    endtask

    task automatic write_data(input logic [7:0] b, input logic [6:0] addr);
        strobe(b);
        check("wr_strobe_pulse", 128'(wr_strobe), 128'd1);
        check("wr_addr", 128'(wr_addr), 128'(addr));
        idle(1);
        check("wr_strobe_drop", 128'(wr_strobe), 128'd0);
        idle(6);
    endtask

    logic [7:0] v1, v2, v3;

    initial begin
        rstn       = 1'b0;
        frame_rstn = 1'b1;
        byte_in    = 8'h00;
        byte_valid = 1'b0;
        #12;
        check("rst_reg_out", 128'(reg_out), {NREGS{RVAL}});
        check("rst_poci", 128'(poci), 128'd0);
        check("rst_wr_strobe", 128'(wr_strobe), 128'd0);
        check("rst_wr_addr", 128'(wr_addr), 128'd0);
        check("rst_rd_active", 128'(rd_active), 128'd0);
        @(negedge sclk);
        #1;
        rstn = 1'b1;
        idle(1);

        // Burst write 0x02: 11 22 33
        strobe(8'h02);
        check("cmd_no_strobe", 128'(wr_strobe), 128'd0);
        idle(7);
        write_data(8'h11, 7'd2);
        write_data(8'h22, 7'd3);
        write_data(8'h33, 7'd4);
        check("reg2", 128'(reg_at(2)), 128'h11);
        check("reg3", 128'(reg_at(3)), 128'h22);
        check("reg4", 128'(reg_at(4)), 128'h33);

        // Preload reg5/reg6, then burst read from 0x05
        end_frame();
        strobe(8'h05); idle(7);
        strobe(8'hC3); idle(7);
        strobe(8'h5A); idle(7);
        end_frame();
        check("rd_active_idle", 128'(rd_active), 128'd0);
        strobe(8'h85);
        check("rd_active_rise", 128'(rd_active), 128'd1);
        read_bits(8, v1);
        strobe(8'h00);
        read_bits(8, v2);
        check("burst_read_16", 128'({v1, v2}), 128'hC35A);
        strobe(8'h00);
        read_bits(8, v3);
        check("read_reg7_reset", 128'(v3), 128'hA5);
        check("rd_active_hold", 128'(rd_active), 128'd1);

        // Out-of-range write and pointer wrap
        end_frame();
        strobe(8'h7F); idle(7);
        strobe(8'hEE);
        check("oor_no_strobe", 128'(wr_strobe), 128'd0);
        check("oor_wr_addr", 128'(wr_addr), 128'h7F);
        idle(7);
        strobe(8'h99);
        check("wrap_strobe", 128'(wr_strobe), 128'd1);
        check("wrap_wr_addr", 128'(wr_addr), 128'h00);
        check("wrap_reg0", 128'(reg_at(0)), 128'h99);
        check("oor_no_alias_reg15", 128'(reg_at(15)), 128'hA5);
        idle(7);

        // Read across the end of the bank: reg15 then zero
        end_frame();
        strobe(8'h0F); idle(7);
        strobe(8'h3C); idle(7);
        end_frame();
        strobe(8'h8F);
        read_bits(8, v1);
        check("read_reg15", 128'(v1), 128'h3C);
        strobe(8'h00);
        read_bits(8, v2);
        check("read_oor_zero", 128'(v2), 128'h00);

        // Frame reset in the middle of a read
        end_frame();
        strobe(8'h8F);
        read_bits(3, v1);
        check("partial_bits", 128'(v1[2:0]), 128'b001);
        check("partial_poci_high", 128'(poci), 128'd1);
        frame_rstn = 1'b0;
        #1;
        check("frame_rst_poci", 128'(poci), 128'd0);
        check("frame_rst_rd_active", 128'(rd_active), 128'd0);
        frame_rstn = 1'b1;
        check("frame_rst_keeps_reg15", 128'(reg_at(15)), 128'h3C);
        strobe(8'h07); idle(7);
        strobe(8'h77);
        check("post_frame_cmd_addr", 128'(wr_addr), 128'h07);
        check("post_frame_reg7", 128'(reg_at(7)), 128'h77);
        idle(7);

        // frame_rstn overrides a coincident byte_valid
        frame_rstn = 1'b0;
        byte_in    = 8'h09;
        byte_valid = 1'b1;
        @(posedge sclk);
        #2;
        byte_valid = 1'b0;
        check("prio_no_strobe", 128'(wr_strobe), 128'd0);
        check("prio_reg8", 128'(reg_at(8)), 128'hA5);
        frame_rstn = 1'b1;
        check("prio_wr_addr_held", 128'(wr_addr), 128'h07);
        idle(7);
        strobe(8'h0A); idle(7);
        strobe(8'h5E);
        check("prio_cmd_addr", 128'(wr_addr), 128'h0A);
        check("prio_reg10", 128'(reg_at(10)), 128'h5E);
        check("prio_reg9", 128'(reg_at(9)), 128'hA5);
        idle(2);

        // Chip reset clears the bank and wr_addr
        rstn = 1'b0;
        #1;
        check("rstn_reg_out", 128'(reg_out), {NREGS{RVAL}});
        check("rstn_wr_addr", 128'(wr_addr), 128'd0);
        rstn = 1'b1;
        idle(1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
